// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the execute-stage trace recorder.
//   - FSM state encodings (IDLE/CAPTURE/POST/DRAIN)
//   - ALU op code constants ADD..CMP (0..9)
//   - NZVC flag bit positions
//   - record field width/offset helpers; a record is packed MSB->LSB as
//     {ts, instr, op, result, flags}
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DRAIN   = 2'd3
    } trace_state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam int OP_W    = 4;
    localparam int FLAGS_W = 4;

    // Field offsets, derived from the recorder's width parameters.
    localparam int FLAGS_LSB = 0;

    function automatic int result_lsb();
        return FLAGS_LSB + FLAGS_W;
    endfunction

    function automatic int op_lsb(input int data_w);
        return result_lsb() + data_w;
    endfunction

    function automatic int instr_lsb(input int data_w);
        return op_lsb(data_w) + OP_W;
    endfunction

    function automatic int ts_lsb(input int instr_w, input int data_w);
        return instr_lsb(data_w) + instr_w;
    endfunction

    function automatic int rec_w(input int ts_w, input int instr_w, input int data_w);
        return ts_lsb(instr_w, data_w) + ts_w;
    endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: DEPTH x REC_W record storage for the trace recorder.
//   clk     : write clock
//   we      : write enable
//   wr_addr : write slot
//   wr_data : record to store
//   rd_addr : read slot
//   rd_data : record at rd_addr (asynchronous read)
// Contents are not reset; the owner tracks which slots are valid.
module trace_ring_mem
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int REC_W  = 44,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [REC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [REC_W-1:0]  rd_data
);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: circular trace recorder for the CPU execute stage.
// Records {ts, instr, op, result, flags} for each committed instruction,
// with arm / trigger / post-trigger windows and wrap or stop-when-full modes,
// then drains oldest-first over a valid/ready port.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cap_valid/instr/op/
//   result/flags             : execute-stage commit record
//   arm                      : start capture (IDLE only)
//   trig                     : trigger (CAPTURE only)
//   mode_wrap                : 1 = overwrite oldest when full, 0 = stop; latched at arm
//   rd_valid/rd_ready/
//   rd_data/rd_last          : drain port
//   state, count, overflow   : status
//   filter_mask              : only with EXEC_TRACE_FILTER_EN; per-op capture enable
//
// Build option: define EXEC_TRACE_FILTER_EN to add the op-code capture filter.
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter  int INSTR_W   = 16,
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 8,
    parameter  int TS_W      = 12,
    parameter  int POST_TRIG = 2,
    localparam int REC_W     = rec_w(TS_W, INSTR_W, DATA_W),
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_valid,
    input  logic [INSTR_W-1:0] cap_instr,
    input  logic [3:0]         cap_op,
    input  logic [DATA_W-1:0]  cap_result,
    input  logic [3:0]         cap_flags,
    input  logic               arm,
    input  logic               trig,
    input  logic               mode_wrap,
`ifdef EXEC_TRACE_FILTER_EN
    input  logic [15:0]        filter_mask,
`endif
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [REC_W-1:0]   rd_data,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);

    trace_state_t      st_q, st_d;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  post_q;
    logic [TS_W-1:0]   ts_q;
    logic              ovf_q;
    logic              wrap_q;

    logic              cap_en;
    logic              in_cap;
    logic              full;
    logic              mem_we;
    logic              drop;
    logic              rd_fire;
    logic              arm_go;
    logic [REC_W-1:0]  wr_rec;

    function automatic logic [TS_W-1:0] ts_sat_inc(input logic [TS_W-1:0] t);
        return (&t) ? t : t + TS_W'(1);
    endfunction

`ifdef EXEC_TRACE_FILTER_EN
    assign cap_en = cap_valid & filter_mask[cap_op];
`else
    assign cap_en = cap_valid;
`endif

    assign in_cap = (st_q == ST_CAPTURE) || (st_q == ST_POST);
    assign full   = (cnt_q == DEPTH_C);
    // A full buffer still accepts the write in wrap mode (oldest is lost);
    // in stop mode the record is dropped and capture ends.
    assign mem_we = in_cap & cap_en & (~full | wrap_q);
    assign drop   = in_cap & cap_en & full & ~wrap_q;
    assign arm_go = (st_q == ST_IDLE) & arm;
    assign wr_rec = {ts_q, cap_instr, cap_op, cap_result, cap_flags};

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (arm) st_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (drop) begin
                    st_d = ST_DRAIN;
                end else if (trig) begin
                    st_d = (POST_TRIG == 0) ? ST_DRAIN : ST_POST;
                end
            end
            ST_POST: begin
                // post_q is at least 1 here; the last post-trigger write closes the window
                if (drop || (mem_we && post_q == CNT_W'(1))) st_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                rd_valid = (cnt_q != '0);
                rd_last  = (cnt_q == CNT_W'(1));
                if (!rd_valid || (rd_ready && rd_last)) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign rd_fire = rd_valid & rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            post_q <= '0;
            ts_q   <= '0;
            ovf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (arm_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            post_q <= '0;
            ts_q   <= '0;
            ovf_q  <= 1'b0;
            wrap_q <= mode_wrap;
        end else begin
            if (in_cap) begin
                ts_q <= ts_sat_inc(ts_q);
            end
            if ((st_q == ST_CAPTURE) && trig) begin
                post_q <= POST_C;
            end else if ((st_q == ST_POST) && mem_we) begin
                post_q <= post_q - CNT_W'(1);
            end
            if (mem_we) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full) begin
                    // overwrite: oldest slot is now the newest, read side skips it
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    ovf_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                cnt_q  <= cnt_q - CNT_W'(1);
            end
        end
    end

    trace_ring_mem #(
        .DEPTH  (DEPTH),
        .REC_W  (REC_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (wr_rec),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign state    = st_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb_exec_trace_buffer: two recorders (POST_TRIG=2 and POST_TRIG=0) share one
// stimulus stream; each is compared every cycle against a queue-based model.
module tb_exec_trace_buffer;

    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TS_W    = 12;
    localparam int REC_W   = TS_W + INSTR_W + 4 + DATA_W + 4;
    localparam int TS_MAX  = (1 << TS_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, cap_valid, arm, trig, mode_wrap, rd_ready;
    logic [INSTR_W-1:0] cap_instr;
    logic [3:0]         cap_op;
    logic [DATA_W-1:0]  cap_result;
    logic [3:0]         cap_flags;
`ifdef EXEC_TRACE_FILTER_EN
    logic [15:0]        filter_mask;
`endif

    logic               o_valid [2];
    logic               o_last  [2];
    logic [REC_W-1:0]   o_data  [2];
    logic [1:0]         o_state [2];
    logic [2:0]         o_count [2];
    logic               o_ovf   [2];

    exec_trace_buffer #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                        .TS_W(TS_W), .POST_TRIG(2)) dut_pt2 (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_instr(cap_instr),
        .cap_op(cap_op), .cap_result(cap_result), .cap_flags(cap_flags),
        .arm(arm), .trig(trig), .mode_wrap(mode_wrap),
`ifdef EXEC_TRACE_FILTER_EN
        .filter_mask(filter_mask),
`endif
        .rd_valid(o_valid[0]), .rd_ready(rd_ready), .rd_data(o_data[0]),
        .rd_last(o_last[0]), .state(o_state[0]), .count(o_count[0]),
        .overflow(o_ovf[0])
    );

    exec_trace_buffer #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                        .TS_W(TS_W), .POST_TRIG(0)) dut_pt0 (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_instr(cap_instr),
        .cap_op(cap_op), .cap_result(cap_result), .cap_flags(cap_flags),
        .arm(arm), .trig(trig), .mode_wrap(mode_wrap),
`ifdef EXEC_TRACE_FILTER_EN
        .filter_mask(filter_mask),
`endif
        .rd_valid(o_valid[1]), .rd_ready(rd_ready), .rd_data(o_data[1]),
        .rd_last(o_last[1]), .state(o_state[1]), .count(o_count[1]),
        .overflow(o_ovf[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [REC_W-1:0] q0[$];
    logic [REC_W-1:0] q1[$];
    int   m_ph   [2];   // 0 idle, 1 capture, 2 post, 3 drain
    int   m_post [2];
    int   m_ts   [2];
    logic m_ovf  [2];
    logic m_wrap [2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [REC_W-1:0] qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int k, input logic [REC_W-1:0] r);
        if (k == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic model_step(input int k, input int pt);
        logic en, stored, to_drain;
        int nph;
        logic [REC_W-1:0] r;
        if (rst) begin
            m_ph[k] = 0; m_ovf[k] = 1'b0; m_ts[k] = 0; qclear(k);
            return;
        end
        en = cap_valid;
`ifdef EXEC_TRACE_FILTER_EN
        en = en & filter_mask[cap_op];
`endif
        case (m_ph[k])
            0: if (arm) begin
                qclear(k); m_ovf[k] = 1'b0; m_ts[k] = 0; m_wrap[k] = mode_wrap; m_ph[k] = 1;
            end
            1, 2: begin
                stored = 1'b0; to_drain = 1'b0; nph = m_ph[k];
                r = {TS_W'(m_ts[k]), cap_instr, cap_op, cap_result, cap_flags};
                if (en) begin
                    if (qsize(k) < DEPTH) begin
                        qpush(k, r); stored = 1'b1;
                    end else if (m_wrap[k]) begin
                        qpop(k); qpush(k, r); m_ovf[k] = 1'b1; stored = 1'b1;
                    end else begin
                        to_drain = 1'b1;
                    end
                end
                if (m_ph[k] == 1 && trig) begin
                    m_post[k] = pt;
                    if (pt == 0) to_drain = 1'b1; else nph = 2;
                end else if (m_ph[k] == 2 && stored) begin
                    m_post[k]--;
                    if (m_post[k] == 0) to_drain = 1'b1;
                end
                if (m_ts[k] < TS_MAX) m_ts[k]++;
                m_ph[k] = to_drain ? 3 : nph;
            end
            default: begin
                if (qsize(k) == 0) m_ph[k] = 0;
                else if (rd_ready) begin
                    qpop(k);
                    if (qsize(k) == 0) m_ph[k] = 0;
                end
            end
        endcase
    endtask

    task automatic compare(input int k);
        logic ev;
        ev = (m_ph[k] == 3) && (qsize(k) > 0);
        chk($sformatf("state[%0d]", k), 64'(o_state[k]), 64'(m_ph[k]));
        chk($sformatf("count[%0d]", k), 64'(o_count[k]), 64'(qsize(k)));
        chk($sformatf("overflow[%0d]", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
        chk($sformatf("rd_valid[%0d]", k), 64'(o_valid[k]), 64'(ev));
        chk($sformatf("rd_last[%0d]", k), 64'(o_last[k]), 64'(ev && qsize(k) == 1));
        if (ev) chk($sformatf("rd_data[%0d]", k), 64'(o_data[k]), 64'(qfront(k)));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 2);
        model_step(1, 0);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic clr_in();
        rst = 1'b0; cap_valid = 1'b0; arm = 1'b0; trig = 1'b0;
    endtask

    task automatic set_cap(input logic [DATA_W-1:0] res, input logic [3:0] op);
        cap_valid  = 1'b1;
        cap_result = res;
        cap_op     = op;
        cap_instr  = INSTR_W'($urandom);
        cap_flags  = 4'($urandom);
    endtask

    task automatic commit(input logic [DATA_W-1:0] res);
        set_cap(res, 4'($urandom_range(0, 9)));
        step();
        clr_in();
    endtask

    task automatic arm_mode(input logic w);
        arm = 1'b1; mode_wrap = w; step(); clr_in();
    endtask

    task automatic pulse_rst();
        rst = 1'b1; step(); clr_in();
    endtask

    function automatic logic [7:0] res_of(input logic [REC_W-1:0] d);
        return d[11:4];
    endfunction

    function automatic logic [TS_W-1:0] ts_of(input logic [REC_W-1:0] d);
        return d[REC_W-1 -: TS_W];
    endfunction

    initial begin
        clr_in();
        mode_wrap = 1'b0; rd_ready = 1'b0;
        cap_instr = '0; cap_op = '0; cap_result = '0; cap_flags = '0;
`ifdef EXEC_TRACE_FILTER_EN
        filter_mask = 16'hFFFF;
`endif
        rst = 1'b1;
        step(); step();
        clr_in();
        chk("reset_state", 64'(o_state[0]), 64'd0);
        chk("reset_count", 64'(o_count[0]), 64'd0);

        // reset mid-capture with 3 records stored
        arm_mode(1'b0);
        for (int i = 1; i <= 3; i++) commit(8'(i));
        chk("mid_count", 64'(o_count[0]), 64'd3);
        pulse_rst();
        chk("midrst_state", 64'(o_state[0]), 64'd0);
        chk("midrst_count", 64'(o_count[0]), 64'd0);
        chk("midrst_valid", 64'(o_valid[0]), 64'd0);
        chk("midrst_ovf", 64'(o_ovf[0]), 64'd0);

        // stop mode: 5th commit dropped
        arm_mode(1'b0);
        for (int i = 1; i <= 5; i++) commit(8'(i));
        chk("stop_state", 64'(o_state[0]), 64'd3);
        chk("stop_count", 64'(o_count[0]), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stop_result", 64'(res_of(o_data[0])), 64'(i + 1));
            chk("stop_ts", 64'(ts_of(o_data[0])), 64'(i));
            chk("stop_last", 64'(o_last[0]), 64'(i == 3));
            step();
        end
        chk("stop_idle", 64'(o_state[0]), 64'd0);
        rd_ready = 1'b0;
        pulse_rst();

        // wrap mode, POST_TRIG=0 instance
        arm_mode(1'b1);
        for (int i = 10; i <= 15; i++) commit(8'(i));
        trig = 1'b1; step(); clr_in();
        chk("wrap_state", 64'(o_state[1]), 64'd3);
        chk("wrap_ovf", 64'(o_ovf[1]), 64'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_result", 64'(res_of(o_data[1])), 64'(12 + i));
            step();
        end
        rd_ready = 1'b0;
        pulse_rst();

        // trigger window then backpressure
        arm_mode(1'b0);
        commit(8'd1);
        set_cap(8'd7, 4'd0); trig = 1'b1; step(); clr_in();
        commit(8'd8); commit(8'd9); commit(8'd10);
        chk("trig_state", 64'(o_state[0]), 64'd3);
        chk("trig_count", 64'(o_count[0]), 64'd4);
        rd_ready = 1'b1;
        chk("bp_first", 64'(res_of(o_data[0])), 64'd1);
        step();
        rd_ready = 1'b0;
        chk("bp_second", 64'(res_of(o_data[0])), 64'd7);
        step();
        chk("bp_hold1", 64'(res_of(o_data[0])), 64'd7);
        step();
        chk("bp_hold2", 64'(res_of(o_data[0])), 64'd7);
        rd_ready = 1'b1;
        step();
        chk("bp_count", 64'(o_count[0]), 64'd2);
        chk("bp_next", 64'(res_of(o_data[0])), 64'd8);
        step(); step();
        chk("bp_idle", 64'(o_state[0]), 64'd0);
        rd_ready = 1'b0;
        pulse_rst();

`ifdef EXEC_TRACE_FILTER_EN
        filter_mask = 16'h0200;
        arm_mode(1'b0);
        set_cap(8'd1, 4'd0); step(); clr_in();
        set_cap(8'd2, 4'd9); step(); clr_in();
        set_cap(8'd3, 4'd1); step(); clr_in();
        set_cap(8'd4, 4'd9); step(); clr_in();
        chk("filter_count", 64'(o_count[0]), 64'd2);
        filter_mask = 16'hFFFF;
        pulse_rst();
`endif

        // timestamp saturation
        arm_mode(1'b0);
        repeat (TS_MAX + 5) step();
        set_cap(8'h55, 4'd2); trig = 1'b1; step(); clr_in();
        chk("ts_sat", 64'(ts_of(o_data[1])), 64'(TS_MAX));
        pulse_rst();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            arm        = ($urandom_range(0, 3) == 0);
            trig       = ($urandom_range(0, 11) == 0);
            mode_wrap  = 1'($urandom_range(0, 1));
            cap_valid  = ($urandom_range(0, 2) != 0);
            cap_instr  = INSTR_W'($urandom);
            cap_op     = 4'($urandom_range(0, 9));
            cap_result = DATA_W'($urandom);
            cap_flags  = 4'($urandom);
            rd_ready   = ($urandom_range(0, 3) != 0);
`ifdef EXEC_TRACE_FILTER_EN
            filter_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Parametrised, synthesizable trace recorder for the CPU's execute stage. Captures one record per committed instruction into a circular buffer: instruction word, op code, ALU result, NZVC flags and a cycle timestamp. Supports arm, trigger and post-trigger windows, plus wrap or stop-when-full modes. Sits beside `CPU`, fed from its execute-stage outputs, and is drained over a valid/ready port by a debug host or testbench.

## Interface
Parameters:
- `INSTR_W`, 16: instruction word width.
- `DATA_W`, 8: ALU result width.
- `DEPTH`, 8: record slots; power of two, ≥2.
- `TS_W`, 12: timestamp width.
- `POST_TRIG`, 2: records captured after the trigger record; 0..DEPTH-1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cap_valid`, in, 1: execute stage committed a result this cycle.
- `cap_instr`, in, INSTR_W: committed instruction.
- `cap_op`, in, 4: op code (ADD=0 … CMP=9).
- `cap_result`, in, DATA_W: ALU result.
- `cap_flags`, in, 4: {N,Z,V,C}.
- `arm`, in, 1: start capture; honoured only in IDLE.
- `trig`, in, 1: trigger.
- `mode_wrap`, in, 1: 1 = overwrite oldest when full; 0 = stop when full. Sampled at arm.
- `rd_valid`, out, 1: record available.
- `rd_ready`, in, 1: host accepts record.
- `rd_data`, out, REC_W: {ts, instr, op, result, flags}, where REC_W = TS_W+INSTR_W+4+DATA_W+4.
- `rd_last`, out, 1: current record is the final one.
- `state`, out, 2: FSM state.
- `count`, out, clog2(DEPTH)+1: stored records.
- `overflow`, out, 1: sticky; a record was overwritten.

## Operation
- States: IDLE(0), CAPTURE(1), POST(2), DRAIN(3).
- IDLE, on `arm`:
  - Clear pointers, `count`, `overflow` and timestamp.
  - Latch `mode_wrap`.
  - Go to CAPTURE.
- CAPTURE/POST: each cycle with `cap_valid` writes one record at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Timestamp: increments every cycle in CAPTURE and POST. It saturates at all-ones. A record carries the pre-increment value.
- Full (`count`==DEPTH), wrap mode: the write overwrites the oldest record. `rd_ptr` advances, `count` stays DEPTH and `overflow` sets.
- Full, stop mode: go to DRAIN. The record presented that cycle is dropped.
- `trig` in CAPTURE:
  - A `cap_valid` record in the same cycle is stored as the trigger record.
  - A post counter loads POST_TRIG.
  - Go to POST, or straight to DRAIN if POST_TRIG==0.
- POST: each stored record decrements the post counter. Reaching 0 goes to DRAIN. Stop-mode full also goes to DRAIN. `trig` is ignored.
- DRAIN:
  - `rd_valid` = (`count`≠0). `rd_data` = mem[`rd_ptr`], oldest first.
  - A handshake (`rd_valid`&`rd_ready`) increments `rd_ptr` and decrements `count`.
  - `rd_last` = (`count`==1).
  - When `count` reaches 0, go to IDLE.
  - Entering DRAIN with `count`==0 returns to IDLE the next cycle.
- `cap_valid`, `trig` and `arm` are ignored outside their states.
- `rst` overrides everything, including mid-capture and mid-drain. Memory contents need not clear.

## Timing
- Reset values: `state`=IDLE, `count`=0, `overflow`=0, `rd_valid`=0, `rd_last`=0. `rd_data` is don't-care while `rd_valid`=0.
- All state, pointer and count updates occur at the `clk` edge where the condition is sampled. `count` reflects a write one cycle after `cap_valid`.
- Earliest `rd_valid` is the cycle after the transition to DRAIN.
- `rd_data` and `rd_last` are combinational from `rd_ptr`/`count`. They are stable while `rd_valid`&!`rd_ready`.
- One record per cycle on both write and read sides; a full drain of N records takes N cycles with `rd_ready` held high.

## Configuration
- `EXEC_TRACE_FILTER_EN` defined:
  - Adds input `filter_mask`, 16 bits.
  - A record is captured only when `cap_valid` & `filter_mask[cap_op]`.
  - Filtered cycles still advance the timestamp but do not count toward POST_TRIG.
  - `trig` still acts on filtered cycles.
- Undefined: the port is absent and every `cap_valid` is captured.

## Structure
- Shared package `trace_pkg` holds:
  - State encodings.
  - Op code constants ADD..CMP (0..9).
  - Flag bit positions (N=3, Z=2, V=1, C=0).
  - Record field offset/width localparams derived from the parameters.
- Sub-module `trace_ring_mem`: DEPTH×REC_W storage with one synchronous write port and one asynchronous read port. The FSM, pointers, counters and timestamp stay in `exec_trace_buffer`.

## Test plan
All scenarios use DEPTH=4, POST_TRIG=2, TS_W=12.
- Reset: assert `rst` mid-CAPTURE with `count`=3 → next cycle `state`=0, `count`=0, `rd_valid`=0, `overflow`=0.
- Stop mode:
  - Stimulus: arm with `mode_wrap`=0, then 5 consecutive commits with results 1..5.
  - Response: DRAIN entered, `count`=4, record 5 dropped, drained results 1,2,3,4 with timestamps 0,1,2,3 and `rd_last` on the 4th.
- Wrap mode:
  - Stimulus: arm with `mode_wrap`=1, 6 commits with results 10..15, then `trig` alone with POST_TRIG=0 (reconfigured).
  - Response: `overflow`=1, drain yields 12,13,14,15.
- Trigger window: 1 commit, then `trig` with a commit of result 7, then 3 more commits with results 8,9,10 → buffer holds results 1,7,8,9. Result 10 is ignored after DRAIN. `count`=4.
- Backpressure: in DRAIN, toggle `rd_ready` 1,0,0,1 → `rd_data` held across stall cycles, exactly 2 records consumed, `count` decrements from 4 to 2.
- Filter (`EXEC_TRACE_FILTER_EN`): `filter_mask`=16'h0200, commits with ops ADD, CMP, SUB, CMP → only the 2 CMP records are stored.
